// File: rtl/rsa_dec_check_if.sv
// Bus bundle between the encryptor-side driver and the RSA decrypt/check stage.
// The master drives the ciphertext, key material and reference message. The slave returns the result.
interface rsa_dec_check_if #(
    parameter int W = 128
);
    logic         enc_done;
    logic [W-1:0] c;
    logic [W-1:0] d_key;
    logic [W-1:0] n;
    logic [W-1:0] msg_ref;
    logic [W-1:0] m;
    logic         match;
    logic         err;
    logic         busy;
    logic         done;

    modport master (
        output enc_done, c, d_key, n, msg_ref,
        input  m, match, err, busy, done
    );

    modport slave (
        input  enc_done, c, d_key, n, msg_ref,
        output m, match, err, busy, done
    );
endinterface

// File: rtl/rsa_dec_check.sv
// RSA decrypt-and-compare stage: m = c^d mod n by left-to-right square-and-multiply
// over a bit-serial interleaved modular multiplier, then checks m against msg_ref.
module rsa_dec_check #(
    parameter int W = 128
) (
    input logic              clk,
    input logic              reset,
    rsa_dec_check_if.slave   bus
);
    localparam int IW = $clog2(W);
    localparam logic [IW-1:0] IDX_TOP  = IW'(W - 1);
    localparam logic [IW-1:0] IDX_ZERO = {IW{1'b0}};
    localparam logic [W-1:0]  ONE_W    = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0]  ZERO_W   = {W{1'b0}};

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SQR, S_MUL, S_FIN} state_e;

    state_e        state_q, state_d;
    logic          edge_q;
    logic [W-1:0]  c_q, c_d, e_q, e_d, n_q, n_d, ref_q, ref_d;
    logic [W-1:0]  acc_q, acc_d, m_q, m_d;
    logic [W:0]    r_q, r_d;
    logic [IW-1:0] k_q, k_d, i_q, i_d;
    logic          match_q, match_d, err_q, err_d, busy_q, busy_d, done_q, done_d;

    logic [W:0]    n_ext_s, mm_b_s, mm_dbl_s, mm_red_s, mm_sum_s, mm_t_s;

    assign bus.m     = m_q;
    assign bus.match = match_q;
    assign bus.err   = err_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

    // One step of the interleaved modmul: r <- (2r + a[k]*b) mod n, kept below n.
    always_comb begin
        n_ext_s  = {1'b0, n_q};
        mm_b_s   = (state_q == S_MUL) ? {1'b0, c_q} : {1'b0, acc_q};
        mm_dbl_s = r_q << 1;
        if (mm_dbl_s >= n_ext_s) mm_red_s = mm_dbl_s - n_ext_s;
        else                     mm_red_s = mm_dbl_s;
        if (acc_q[k_q])          mm_sum_s = mm_red_s + mm_b_s;
        else                     mm_sum_s = mm_red_s;
        if (mm_sum_s >= n_ext_s) mm_t_s   = mm_sum_s - n_ext_s;
        else                     mm_t_s   = mm_sum_s;
    end

    // Next-state and datapath update for the decrypt sequence.
    always_comb begin
        state_d = state_q;
        c_d = c_q; e_d = e_q; n_d = n_q; ref_d = ref_q;
        acc_d = acc_q; r_d = r_q; k_d = k_q; i_d = i_q;
        m_d = m_q; match_d = match_q; err_d = err_q; busy_d = busy_q; done_d = done_q;
        case (state_q)
            S_IDLE: begin
                if (bus.enc_done && !edge_q) begin
                    c_d = bus.c; e_d = bus.d_key; n_d = bus.n; ref_d = bus.msg_ref;
                    acc_d = ONE_W; r_d = {(W+1){1'b0}};
                    i_d = IDX_TOP; k_d = IDX_TOP;
                    done_d = 1'b0; match_d = 1'b0; err_d = 1'b0; busy_d = 1'b1;
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if ((n_q <= ONE_W) || (c_q >= n_q)) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else begin
                    state_d = S_SQR;
                end
            end
            S_SQR, S_MUL: begin
                r_d = mm_t_s;
                if (k_q == IDX_ZERO) begin
                    // Last modmul cycle also carries the exponent-bit bookkeeping.
                    acc_d = mm_t_s[W-1:0];
                    r_d   = {(W+1){1'b0}};
                    k_d   = IDX_TOP;
                    if ((state_q == S_SQR) && e_q[i_q]) begin
                        state_d = S_MUL;
                    end else if (i_q == IDX_ZERO) begin
                        state_d = S_FIN;
                    end else begin
                        i_d     = i_q - IW'(1);
                        state_d = S_SQR;
                    end
                end else begin
                    k_d = k_q - IW'(1);
                end
            end
            S_FIN: begin
                m_d     = err_q ? ZERO_W : acc_q;
                match_d = (acc_q == ref_q) && !err_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            edge_q  <= 1'b0;
            c_q <= ZERO_W; e_q <= ZERO_W; n_q <= ZERO_W; ref_q <= ZERO_W;
            acc_q <= ZERO_W; r_q <= {(W+1){1'b0}};
            k_q <= IDX_ZERO; i_q <= IDX_ZERO;
            m_q <= ZERO_W; match_q <= 1'b0; err_q <= 1'b0; busy_q <= 1'b0; done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            edge_q  <= bus.enc_done;
            c_q <= c_d; e_q <= e_d; n_q <= n_d; ref_q <= ref_d;
            acc_q <= acc_d; r_q <= r_d;
            k_q <= k_d; i_q <= i_d;
            m_q <= m_d; match_q <= match_d; err_q <= err_d; busy_q <= busy_d; done_q <= done_d;
        end
    end
endmodule
